// File: rtl/bullet_pkg.sv
// bullet_pkg: shared types and constants for the player bullet pool
package bullet_pkg;
  localparam int DEF_COORD_W = 10;
  localparam logic [7:0] KEY_SPACE = 8'h2c;
  typedef logic [DEF_COORD_W-1:0] coord_t;
  typedef enum logic {IDLE, FLY} slot_state_e;
  typedef enum logic {READY, COOL} fire_state_e;
endpackage

// File: rtl/bullet_slot.sv
// bullet_slot: one projectile; tracks the ship while idle, climbs once per frame while flying
module bullet_slot
  import bullet_pkg::*;
#(
  parameter int COORD_W      = DEF_COORD_W,
  parameter int BULLET_SIZE  = 3,
  parameter int BULLET_SPEED = 8,
  parameter int Y_MIN        = 15
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               launch,
  input  logic               hit,
  input  logic [COORD_W-1:0] ship_x,
  input  logic [COORD_W-1:0] ship_y,
  output logic               active,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);
  localparam int LIMIT = Y_MIN + (BULLET_SPEED >> 2) + BULLET_SIZE;
  slot_state_e state, state_n;
  logic [COORD_W-1:0] x_n, y_n;
  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      x <= ship_x;
      y <= ship_y;
    end else begin
      state <= state_n;
      x <= x_n;
      y <= y_n;
    end
  // x/y default to the ship so idle slots and freshly retired slots reload from it
  always_comb begin
    state_n = state;
    x_n = ship_x;
    y_n = ship_y;
    if (state == FLY) begin
      if (hit || y < COORD_W'(LIMIT)) state_n = IDLE;
      else begin
        x_n = x;
        y_n = y - COORD_W'(BULLET_SPEED);
      end
    end else if (launch) state_n = FLY;
  end
  assign active = state == FLY;
endmodule

// File: rtl/bullet_pool.sv
// bullet_pool: multi-shot projectile engine with key edge detect, lowest-slot allocator and shot cooldown
// AUTOFIRE_EN: when defined, holding the fire key refires every COOLDOWN frames.
module bullet_pool
  import bullet_pkg::*;
#(
  parameter int NUM_BULLETS   = 4,
  parameter int COORD_W       = DEF_COORD_W,
  parameter int BULLET_SIZE   = 3,
  parameter int BULLET_SPEED  = 8,
  parameter int Y_MIN         = 15,
  parameter logic [7:0] FIRE_KEY = KEY_SPACE,
  parameter int COOLDOWN      = 8
) (
  input  logic                           frame_clk,
  input  logic                           Reset,
  input  logic [COORD_W-1:0]             ship_x,
  input  logic [COORD_W-1:0]             ship_y,
  input  logic [23:0]                    keycodes,
  input  logic [NUM_BULLETS-1:0]         hit,
  output logic [NUM_BULLETS-1:0]         active,
  output logic [NUM_BULLETS*COORD_W-1:0] bullet_x,
  output logic [NUM_BULLETS*COORD_W-1:0] bullet_y,
  output logic [COORD_W-1:0]             bullet_size,
  output logic                           fire_pulse
);
  localparam int CNT_W = COOLDOWN > 1 ? $clog2(COOLDOWN) : 1;
  if (Y_MIN + (BULLET_SPEED >> 2) + BULLET_SIZE < BULLET_SPEED) begin : g_bad_limit
    $error("bullet_pool: retire limit below BULLET_SPEED lets y wrap");
  end
  if (NUM_BULLETS < 1 || NUM_BULLETS > 8 || COOLDOWN < 1) begin : g_bad_cfg
    $error("bullet_pool: NUM_BULLETS must be 1..8 and COOLDOWN >= 1");
  end
  fire_state_e fstate, fstate_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic key_now, key_prev, fire_req, accept;
  logic [NUM_BULLETS-1:0] free, launch;
  assign key_now = keycodes[23:16] == FIRE_KEY || keycodes[15:8] == FIRE_KEY || keycodes[7:0] == FIRE_KEY;
`ifdef AUTOFIRE_EN
  assign fire_req = key_now;
`else
  assign fire_req = key_now & ~key_prev;
`endif
  assign free = ~active;
  assign accept = fstate == READY && fire_req && ship_y > COORD_W'(Y_MIN) && |free;
  // free & -free isolates the lowest-index idle slot
  assign launch = accept ? (free & -free) : '0;
  assign bullet_size = COORD_W'(BULLET_SIZE);
  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset) begin
      fstate <= READY;
      cnt <= '0;
      key_prev <= 1'b0;
      fire_pulse <= 1'b0;
    end else begin
      fstate <= fstate_n;
      cnt <= cnt_n;
      key_prev <= key_now;
      fire_pulse <= accept;
    end
  always_comb begin
    fstate_n = fstate;
    cnt_n = cnt;
    if (fstate == COOL) begin
      cnt_n = cnt - 1'b1;
      fstate_n = cnt == CNT_W'(1) ? READY : COOL;
    end else if (accept) begin
      cnt_n = CNT_W'(COOLDOWN - 1);
      fstate_n = COOLDOWN == 1 ? READY : COOL;
    end
  end
  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
    bullet_slot #(
      .COORD_W(COORD_W),
      .BULLET_SIZE(BULLET_SIZE),
      .BULLET_SPEED(BULLET_SPEED),
      .Y_MIN(Y_MIN)
    ) u_slot (
      .frame_clk(frame_clk),
      .Reset(Reset),
      .launch(launch[i]),
      .hit(hit[i]),
      .ship_x(ship_x),
      .ship_y(ship_y),
      .active(active[i]),
      .x(bullet_x[i*COORD_W +: COORD_W]),
      .y(bullet_y[i*COORD_W +: COORD_W])
    );
  end
endmodule

// File: tb/tb_bullet_pool.sv
// tb_bullet_pool: directed and randomized checks of bullet_pool against a frame-level reference model
module tb_bullet_pool;
  localparam int NB = 4;
  localparam int W = 10;
  localparam int COOLDOWN = 8;
  localparam int LIMIT = 20;
  logic frame_clk = 0, Reset = 0;
  logic [W-1:0] sx = 10'd320, sy = 10'd400;
  logic [23:0] kc = '0;
  logic [NB-1:0] hit = '0;
  logic [NB-1:0] active;
  logic [NB*W-1:0] bullet_x, bullet_y;
  logic [W-1:0] bullet_size;
  logic fire_pulse;
  int cmp = 0, mism = 0;
  bit m_act[NB];
  int m_x[NB], m_y[NB];
  bit m_kprev, m_pulse;
  int frame, last_acc;

  bullet_pool dut (
    .frame_clk(frame_clk), .Reset(Reset), .ship_x(sx), .ship_y(sy), .keycodes(kc), .hit(hit),
    .active(active), .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_size(bullet_size),
    .fire_pulse(fire_pulse)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_act[i] = 0; m_x[i] = int'(sx); m_y[i] = int'(sy);
    end
    m_kprev = 0; m_pulse = 0; frame = 0; last_acc = -1000;
  endtask

  // One frame of game rules: shots need a key edge, COOLDOWN frames since the last shot and a free slot
  task automatic model_step();
    bit kn, req, acc;
    int a;
    kn = kc[23:16] == 8'h2c || kc[15:8] == 8'h2c || kc[7:0] == 8'h2c;
    req = kn && !m_kprev;
    m_kprev = kn;
    a = -1;
    for (int i = NB - 1; i >= 0; i--) if (!m_act[i]) a = i;
    acc = req && (frame - last_acc >= COOLDOWN) && int'(sy) > 15 && a >= 0;
    for (int i = 0; i < NB; i++) begin
      if (m_act[i] && !hit[i] && m_y[i] >= LIMIT) m_y[i] -= 8;
      else begin
        m_act[i] = !m_act[i] && acc && i == a;
        m_x[i] = int'(sx); m_y[i] = int'(sy);
      end
    end
    if (acc) last_acc = frame;
    m_pulse = acc;
    frame++;
  endtask

  function automatic logic [NB*(2*W+1):0] exp_all();
    logic [NB-1:0] a;
    logic [NB*W-1:0] x, y;
    for (int i = 0; i < NB; i++) begin
      a[i] = m_act[i];
      x[i*W +: W] = W'(m_x[i]);
      y[i*W +: W] = W'(m_y[i]);
    end
    return {a, x, y, m_pulse};
  endfunction

  task automatic tick();
    @(posedge frame_clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    kc = '0; hit = '0;
    @(negedge frame_clk);
    Reset = 1;
    model_reset();
    @(negedge frame_clk);
    Reset = 0;
  endtask

  task automatic test_reset();
    sx = 10'd100; sy = 10'd200;
    #2 Reset = 1;
    #1;
    cmp++;
    if (active !== 4'b0000 || fire_pulse !== 1'b0) begin
      mism++; $display("FAIL reset_flags active=%b pulse=%b want 0000/0", active, fire_pulse);
    end
    cmp++;
    if (bullet_x !== {NB{sx}} || bullet_y !== {NB{sy}}) begin
      mism++; $display("FAIL reset_pos x=%h y=%h want %h/%h", bullet_x, bullet_y, {NB{sx}}, {NB{sy}});
    end
    cmp++;
    if (bullet_size !== 10'd3) begin
      mism++; $display("FAIL bullet_size got=%0d want 3", bullet_size);
    end
    model_reset();
    @(negedge frame_clk);
    Reset = 0;
  endtask

  task automatic test_single_shot();
    sx = 10'd320; sy = 10'd400;
    do_reset();
    kc = 24'h002c00;
    tick();
    cmp++;
    if (active !== 4'b0001 || bullet_y[9:0] !== 10'd400 || bullet_x[9:0] !== 10'd320 || fire_pulse !== 1'b1) begin
      mism++; $display("FAIL shot_launch active=%b y0=%0d pulse=%b want 0001/400/1", active, bullet_y[9:0], fire_pulse);
    end
    kc = '0;
    for (int f = 1; f <= 52; f++) begin
      tick();
      cmp++;
      if ({active, bullet_x, bullet_y, fire_pulse} !== exp_all()) begin
        mism++; $display("FAIL single_shot f=%0d got=%h want=%h", f, {active, bullet_x, bullet_y, fire_pulse}, exp_all());
      end
    end
    cmp++;
    if (active !== 4'b0000) begin
      mism++; $display("FAIL shot_retire active=%b want 0000", active);
    end
  endtask

  task automatic test_hold();
    do_reset();
    kc = 24'h2c0000;
    for (int f = 0; f < 40; f++) begin
      tick();
      cmp++;
      if ({active, bullet_x, bullet_y, fire_pulse} !== exp_all()) begin
        mism++; $display("FAIL hold f=%0d got=%h want=%h", f, {active, bullet_x, bullet_y, fire_pulse}, exp_all());
      end
    end
    cmp++;
    if (active !== 4'b0001) begin
      mism++; $display("FAIL hold_once active=%b want 0001", active);
    end
    kc = '0;
  endtask

  task automatic test_cooldown();
    do_reset();
    for (int f = 0; f < 12; f++) begin
      kc = (f == 0 || f == 3 || f == 8) ? 24'h00002c : 24'h0;
      tick();
      cmp++;
      if (fire_pulse !== (f == 0 || f == 8)) begin
        mism++; $display("FAIL cooldown_pulse f=%0d got=%b want=%b", f, fire_pulse, f == 0 || f == 8);
      end
      cmp++;
      if ({active, bullet_x, bullet_y, fire_pulse} !== exp_all()) begin
        mism++; $display("FAIL cooldown f=%0d got=%h want=%h", f, {active, bullet_x, bullet_y, fire_pulse}, exp_all());
      end
    end
    cmp++;
    if (active !== 4'b0011) begin
      mism++; $display("FAIL cooldown_slots active=%b want 0011", active);
    end
  endtask

  task automatic test_pool_full();
    do_reset();
    for (int f = 0; f < 36; f++) begin
      kc = (f % 8 == 0 || f == 34) ? 24'h2c0000 : 24'h0;
      hit = f == 32 ? 4'b1000 : 4'b0000;
      tick();
      cmp++;
      if ({active, bullet_x, bullet_y, fire_pulse} !== exp_all()) begin
        mism++; $display("FAIL pool_full f=%0d got=%h want=%h", f, {active, bullet_x, bullet_y, fire_pulse}, exp_all());
      end
      if (f == 32) begin
        cmp++;
        if (active !== 4'b0111 || fire_pulse !== 1'b0) begin
          mism++; $display("FAIL full_reject active=%b pulse=%b want 0111/0", active, fire_pulse);
        end
      end
    end
    cmp++;
    if (active !== 4'b1111) begin
      mism++; $display("FAIL full_no_cooldown active=%b want 1111", active);
    end
    hit = '0; kc = '0;
  endtask

  task automatic test_hit_reuse();
    do_reset();
    for (int f = 0; f < 22; f++) begin
      kc = (f == 0 || f == 8 || f == 21) ? 24'h00002c : 24'h0;
      sx = 10'(200 + f);
      hit = f == 20 ? 4'b0010 : 4'b0000;
      tick();
      cmp++;
      if ({active, bullet_x, bullet_y, fire_pulse} !== exp_all()) begin
        mism++; $display("FAIL hit_reuse f=%0d got=%h want=%h", f, {active, bullet_x, bullet_y, fire_pulse}, exp_all());
      end
      if (f == 20) begin
        cmp++;
        if (active !== 4'b0001 || bullet_x[19:10] !== 10'd220 || bullet_y[19:10] !== sy) begin
          mism++; $display("FAIL hit_free active=%b x1=%0d y1=%0d want 0001/220/%0d", active, bullet_x[19:10], bullet_y[19:10], sy);
        end
      end
    end
    cmp++;
    if (active !== 4'b0011 || fire_pulse !== 1'b1 || bullet_x[19:10] !== 10'd221) begin
      mism++; $display("FAIL hit_realloc active=%b pulse=%b x1=%0d want 0011/1/221", active, fire_pulse, bullet_x[19:10]);
    end
    hit = '0; kc = '0;
  endtask

  task automatic test_random();
    sx = 10'd320; sy = 10'd400;
    do_reset();
    for (int f = 0; f < 1500; f++) begin
      kc = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      if ($urandom_range(0, 2) == 0) kc[$urandom_range(0, 2)*8 +: 8] = 8'h2c;
      for (int i = 0; i < NB; i++) hit[i] = $urandom_range(0, 15) == 0;
      sx = 10'($urandom_range(0, 639));
      sy = $urandom_range(0, 4) == 0 ? 10'($urandom_range(0, 20)) : 10'($urandom_range(21, 479));
      tick();
      cmp++;
      if ({active, bullet_x, bullet_y, fire_pulse} !== exp_all()) begin
        mism++; $display("FAIL random f=%0d got=%h want=%h", f, {active, bullet_x, bullet_y, fire_pulse}, exp_all());
      end
    end
    hit = '0; kc = '0;
  endtask

  task automatic test_reset_midflight();
    sx = 10'd320; sy = 10'd400;
    do_reset();
    for (int f = 0; f < 20; f++) begin
      kc = (f % 8 == 0) ? 24'h00002c : 24'h0;
      tick();
    end
    cmp++;
    if (active !== 4'b0111) begin
      mism++; $display("FAIL midflight_pre active=%b want 0111", active);
    end
    #2 Reset = 1;
    #1;
    cmp++;
    if (active !== 4'b0000 || fire_pulse !== 1'b0 || bullet_y !== {NB{sy}}) begin
      mism++; $display("FAIL midflight_reset active=%b pulse=%b y=%h want 0000/0/%h", active, fire_pulse, bullet_y, {NB{sy}});
    end
    model_reset();
    @(negedge frame_clk);
    Reset = 0;
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_hold();
    test_cooldown();
    test_pool_full();
    test_hit_reuse();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule
